// File: rtl/local_mem_arb_2to1.sv
// Two-requester Avalon-MM arbiter onto one local-memory bank: round-robin grant, write-burst lock, in-order read return.
// Optional stall statistics are built when LOCAL_MEM_ARB_STATS_EN is defined.
module local_mem_arb_2to1 #(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 7,
    parameter int RDQ_DEPTH       = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADDR_WIDTH-1:0]        m0_address,
    input  logic [BURST_CNT_WIDTH-1:0]   m0_burstcount,
    input  logic                         m0_read,
    input  logic                         m0_write,
    input  logic [DATA_WIDTH-1:0]        m0_writedata,
    input  logic [DATA_WIDTH/8-1:0]      m0_byteenable,
    output logic                         m0_waitrequest,
    output logic [DATA_WIDTH-1:0]        m0_readdata,
    output logic                         m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]        m1_address,
    input  logic [BURST_CNT_WIDTH-1:0]   m1_burstcount,
    input  logic                         m1_read,
    input  logic                         m1_write,
    input  logic [DATA_WIDTH-1:0]        m1_writedata,
    input  logic [DATA_WIDTH/8-1:0]      m1_byteenable,
    output logic                         m1_waitrequest,
    output logic [DATA_WIDTH-1:0]        m1_readdata,
    output logic                         m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0]        s_address,
    output logic [BURST_CNT_WIDTH-1:0]   s_burstcount,
    output logic                         s_read,
    output logic                         s_write,
    output logic [DATA_WIDTH-1:0]        s_writedata,
    output logic [DATA_WIDTH/8-1:0]      s_byteenable,
    input  logic                         s_waitrequest,
    input  logic [DATA_WIDTH-1:0]        s_readdata,
    input  logic                         s_readdatavalid,
    output logic [31:0]                  stat_m0_stall,
    output logic [31:0]                  stat_m1_stall,
    output logic                         dbg_state
);
    localparam int BW = BURST_CNT_WIDTH;
    localparam int PW = $clog2(RDQ_DEPTH);

    // Handshake: a command or write beat transfers on a cycle where m<i>_read/write=1 and m<i>_waitrequest=0.
    typedef enum logic {ARB = 1'b0, WR_LOCK = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic            lock_owner_q, lock_owner_d;
    logic [BW-1:0]   beats_left_q, beats_left_d;

    logic            rdq_id_q [RDQ_DEPTH];
    logic [BW-1:0]   rdq_bc_q [RDQ_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q;
    logic [BW-1:0]   beat_cnt_q;
    logic            m0_rdv_q, m1_rdv_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic            rdq_full, rdq_empty;
    logic            elig0, elig1, gnt, gnt_valid, accept, push, rtn, pop;
    logic [BW-1:0]   bc_eff;

    assign rdq_full  = (count_q == (PW+1)'(RDQ_DEPTH));
    assign rdq_empty = (count_q == '0);
    // Reads are only eligible for grant while the tracking queue has room.
    assign elig0 = m0_write | (m0_read & ~rdq_full);
    assign elig1 = m1_write | (m1_read & ~rdq_full);
    assign bc_eff = (s_burstcount == '0) ? BW'(1) : s_burstcount;

    always_comb begin
        gnt          = 1'b0;
        gnt_valid    = 1'b0;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_owner_d = lock_owner_q;
        beats_left_d = beats_left_q;
        case (state_q)
            ARB: begin
                if (elig0 && elig1) begin
                    gnt_valid = 1'b1;
                    gnt       = ~last_grant_q;
                end else if (elig0 || elig1) begin
                    gnt_valid = 1'b1;
                    gnt       = elig1;
                end
            end
            WR_LOCK: begin
                gnt       = lock_owner_q;
                gnt_valid = lock_owner_q ? m1_write : m0_write;
            end
            default: ;
        endcase

        s_address    = gnt ? m1_address    : m0_address;
        s_burstcount = gnt ? m1_burstcount : m0_burstcount;
        s_writedata  = gnt ? m1_writedata  : m0_writedata;
        s_byteenable = gnt ? m1_byteenable : m0_byteenable;
        s_write      = gnt_valid & (gnt ? m1_write : m0_write);
        s_read       = gnt_valid & (state_q == ARB) & ~rdq_full & ~s_write
                       & (gnt ? m1_read : m0_read);
        accept       = (s_read | s_write) & ~s_waitrequest;

        if (accept) begin
            last_grant_d = gnt;
            if (state_q == ARB) begin
                if (s_write && bc_eff != BW'(1)) begin
                    state_d      = WR_LOCK;
                    lock_owner_d = gnt;
                    beats_left_d = bc_eff - BW'(1);
                end
            end else begin
                beats_left_d = beats_left_q - BW'(1);
                if (beats_left_q == BW'(1)) state_d = ARB;
            end
        end
    end

    assign m0_waitrequest = ~(accept & ~gnt);
    assign m1_waitrequest = ~(accept & gnt);
    assign dbg_state      = (state_q == WR_LOCK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB;
            last_grant_q <= 1'b1;
            lock_owner_q <= 1'b0;
            beats_left_q <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_owner_q <= lock_owner_d;
            beats_left_q <= beats_left_d;
        end
    end

    // Return beats are routed by the oldest outstanding read; stray beats on an empty queue are dropped.
    assign push = accept & s_read;
    assign rtn  = s_readdatavalid & ~rdq_empty;
    assign pop  = rtn & (beat_cnt_q == rdq_bc_q[rd_ptr_q] - BW'(1));

    always_ff @(posedge clk) begin
        if (push) begin
            rdq_id_q[wr_ptr_q] <= gnt;
            rdq_bc_q[wr_ptr_q] <= bc_eff;
        end
        rdata_q <= s_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= '0;
            m0_rdv_q   <= 1'b0;
            m1_rdv_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
            if (rtn) beat_cnt_q <= pop ? '0 : beat_cnt_q + BW'(1);
            m0_rdv_q <= rtn & ~rdq_id_q[rd_ptr_q];
            m1_rdv_q <= rtn & rdq_id_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (!(s_readdatavalid && rdq_empty));
    end

    assign m0_readdata      = rdata_q;
    assign m1_readdata      = rdata_q;
    assign m0_readdatavalid = m0_rdv_q;
    assign m1_readdatavalid = m1_rdv_q;

`ifdef LOCAL_MEM_ARB_STATS_EN
    logic [31:0] stat0_q, stat1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if ((m0_read | m0_write) & m0_waitrequest & (stat0_q != '1)) stat0_q <= stat0_q + 32'd1;
            if ((m1_read | m1_write) & m1_waitrequest & (stat1_q != '1)) stat1_q <= stat1_q + 32'd1;
        end
    end

    assign stat_m0_stall = stat0_q;
    assign stat_m1_stall = stat1_q;
`else
    assign stat_m0_stall = '0;
    assign stat_m1_stall = '0;
`endif

endmodule

// File: tb/tb_local_mem_arb_2to1.sv
// Bench for local_mem_arb_2to1: grant/command vector table, multi-cycle corner sequences, read-return scoreboard.
module tb_local_mem_arb_2to1;
    localparam int AW = 27;
    localparam int DW = 512;
    localparam int BW = 7;
    localparam logic [AW-1:0] A0 = 27'h0000100;
    localparam logic [AW-1:0] A1 = 27'h0000200;
`ifdef LOCAL_MEM_ARB_STATS_EN
    localparam int STAT_EXP = 10;
`else
    localparam int STAT_EXP = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0] m0_address, m1_address, s_address;
    logic [BW-1:0] m0_burstcount, m1_burstcount, s_burstcount;
    logic m0_read, m0_write, m1_read, m1_write, s_read, s_write;
    logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
    logic [DW/8-1:0] m0_byteenable, m1_byteenable, s_byteenable;
    logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
    logic s_waitrequest, s_readdatavalid, dbg_state;
    logic [31:0] stat_m0_stall, stat_m1_stall;

    local_mem_arb_2to1 dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
        .stat_m0_stall(stat_m0_stall), .stat_m1_stall(stat_m1_stall), .dbg_state(dbg_state)
    );

    int passes = 0;
    int total  = 0;
    // {expected cycle[15:0], requester id, data word[31:0]}
    logic [48:0] exp_q[$];
    logic [48:0] mon_e;
    logic [DW-1:0] mon_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        m0_burstcount = 7'd1; m1_burstcount = 7'd1;
        s_waitrequest = 1'b0; s_readdatavalid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic ret_beat(input logic id, input logic [31:0] r);
        s_readdatavalid = 1'b1;
        s_readdata = {16{r}};
        exp_q.push_back({16'(cyc + 1), id, r});
    endtask

    // Return monitor: every routed beat must match the oldest expectation in cycle, requester and data.
    always @(negedge clk) begin
        if (m0_readdatavalid || m1_readdatavalid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL rdv_unexpected: got m0_rdv=%0b m1_rdv=%0b, expected none (cycle %0d)",
                         m0_readdatavalid, m1_readdatavalid, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_data = mon_e[32] ? m1_readdata : m0_readdata;
                check("rdv_cycle", 64'(cyc[15:0]), 64'(mon_e[48:33]));
                check("rdv_route", {m1_readdatavalid, m0_readdatavalid}, mon_e[32] ? 2'b10 : 2'b01);
                check("rdv_data_lo", mon_data[31:0], mon_e[31:0]);
                check("rdv_data_hi", mon_data[DW-1:DW-32], mon_e[31:0]);
            end
        end
    end

    typedef struct {
        logic m0r, m0w, m1r, m1w, sw;
        logic w0, w1, sr, swr, sel;
    } vec_t;

    initial begin
        vec_t tbl[10];
        int acc0, acc1;
        tbl[0] = '{0,0,0,0,0, 1,1,0,0,0};
        tbl[1] = '{1,0,0,0,1, 1,1,1,0,0};
        tbl[2] = '{1,0,1,0,1, 1,1,1,0,0};
        tbl[3] = '{1,0,1,0,0, 0,1,1,0,0};
        tbl[4] = '{1,0,1,0,0, 1,0,1,0,1};
        tbl[5] = '{0,0,0,1,0, 1,0,0,1,1};
        tbl[6] = '{0,1,0,1,0, 0,1,0,1,0};
        tbl[7] = '{0,1,0,1,0, 1,0,0,1,1};
        tbl[8] = '{0,1,1,0,0, 0,1,0,1,0};
        tbl[9] = '{0,1,1,0,0, 1,0,1,0,1};

        m0_address = A0; m1_address = A1;
        m0_writedata = {16{32'hA0A0_0000}}; m1_writedata = {16{32'hB1B1_0001}};
        m0_byteenable = '1; m1_byteenable = '1;
        s_readdata = '0;
        idle();
        do_reset();

        #1;
        check("rst_rdv0", m0_readdatavalid, 0);
        check("rst_rdv1", m1_readdatavalid, 0);
        check("rst_state", dbg_state, 0);
        check("rst_stat0", stat_m0_stall, 0);
        check("rst_stat1", stat_m1_stall, 0);
        check("rst_wait", {m0_waitrequest, m1_waitrequest}, 2'b11);

        // Grant/command table; m1 uses burstcount 0, which must behave as a single beat.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m0_read = tbl[i].m0r; m0_write = tbl[i].m0w;
            m1_read = tbl[i].m1r; m1_write = tbl[i].m1w;
            s_waitrequest = tbl[i].sw;
            m0_burstcount = 7'd1; m1_burstcount = 7'd0;
            #1;
            check($sformatf("vec%0d_wait", i), {m0_waitrequest, m1_waitrequest}, {tbl[i].w0, tbl[i].w1});
            check($sformatf("vec%0d_cmd", i), {s_read, s_write}, {tbl[i].sr, tbl[i].swr});
            if (tbl[i].sr || tbl[i].swr)
                check($sformatf("vec%0d_addr", i), s_address, tbl[i].sel ? A1 : A0);
            if (tbl[i].swr)
                check($sformatf("vec%0d_wdata", i), s_writedata[31:0], tbl[i].sel ? 32'hB1B1_0001 : 32'hA0A0_0000);
        end
        do_reset();

        // Both requesters read every cycle; each read is returned on the following cycle.
        acc0 = 0; acc1 = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
            s_readdatavalid = 1'b0;
            if (t > 0) ret_beat(((t - 1) % 2) == 1, $urandom());
            #1;
            check("rr_grant", {m0_waitrequest, m1_waitrequest}, (t % 2 == 0) ? 2'b01 : 2'b10);
            acc0 += int'(!m0_waitrequest);
            acc1 += int'(!m1_waitrequest);
        end
        @(negedge clk);
        idle();
        ret_beat(1'b1, $urandom());
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        check("rr_acc0", acc0, 100);
        check("rr_acc1", acc1, 100);
        check("rr_drained", exp_q.size(), 0);

        // m0 4-beat write burst holds off an m1 read until the burst completes.
        do_reset();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            m0_write = 1'b1; m0_burstcount = 7'd4; m1_read = 1'b1;
            #1;
            check("lock_m0_beat", m0_waitrequest, 0);
            check("lock_m1_stall", m1_waitrequest, 1);
            check("lock_state", dbg_state, b > 0);
        end
        @(negedge clk);
        m0_write = 1'b0;
        #1;
        check("lock_release_m1", m1_waitrequest, 0);
        check("lock_release_state", dbg_state, 0);
        check("lock_release_sread", s_read, 1);

        // m0 2-beat read then m1 single read; three return beats in order.
        do_reset();
        @(negedge clk);
        m0_read = 1'b1; m0_burstcount = 7'd2;
        #1;
        check("ret_m0_acc", m0_waitrequest, 0);
        @(negedge clk);
        m0_read = 1'b0; m1_read = 1'b1; m1_burstcount = 7'd1;
        #1;
        check("ret_m1_acc", m1_waitrequest, 0);
        @(negedge clk); idle(); ret_beat(1'b0, 32'hD000_0000);
        @(negedge clk); idle(); ret_beat(1'b0, 32'hD000_0001);
        @(negedge clk); idle(); ret_beat(1'b1, 32'hD000_0002);
        @(negedge clk); idle();
        repeat (3) @(negedge clk);
        check("ret_drained", exp_q.size(), 0);

        // Fill the read queue, then check full stalls reads but not writes.
        do_reset();
        acc0 = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            m0_read = 1'b1;
            #1;
            acc0 += int'(!m0_waitrequest);
        end
        check("fill_acc", acc0, 64);
        @(negedge clk);
        #1;
        check("full_stall", m0_waitrequest, 1);
        check("full_no_sread", s_read, 0);
        @(negedge clk);
        m1_write = 1'b1;
        #1;
        check("full_write_ok", m1_waitrequest, 0);
        check("full_read_stall", m0_waitrequest, 1);
        @(negedge clk);
        m1_write = 1'b0;
        ret_beat(1'b0, 32'hF00D_0040);
        #1;
        check("full_pop_cycle_stall", m0_waitrequest, 1);
        @(negedge clk);
        s_readdatavalid = 1'b0;
        #1;
        check("after_pop_accept", m0_waitrequest, 0);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        check("full_drained", exp_q.size(), 0);

        // m1 held by s_waitrequest for 10 cycles.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            m1_read = 1'b1; s_waitrequest = 1'b1;
        end
        @(negedge clk);
        idle();
        #1;
        check("stat_m1", stat_m1_stall, STAT_EXP);
        check("stat_m0", stat_m0_stall, 0);

        // Reset in the middle of a 4-beat write burst.
        do_reset();
        @(negedge clk);
        m0_write = 1'b1; m0_burstcount = 7'd4;
        #1;
        check("mid_beat1", m0_waitrequest, 0);
        @(negedge clk);
        #1;
        check("mid_locked", dbg_state, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle();
        m1_read = 1'b1;
        #1;
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_m1_grant", m1_waitrequest, 0);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        check("final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/local_mem_arb_2to1.md
LOCAL_MEM_ARB_2TO1 -- requirements
Module: local_mem_arb_2to1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 27, word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 512, data bus width; byteenable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter BURST_CNT_WIDTH, default 7, burstcount width.
REQ-004 SHALL have parameter RDQ_DEPTH, default 64, outstanding read-command tracking depth (power of 2).
REQ-005 SHALL have port clk  in  1  single clock for all logic.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports m<i>_address/burstcount/read/write/writedata/byteenable  in  per parameters  Avalon-MM requester i command (i=0,1).
REQ-008 SHALL have ports m<i>_waitrequest  out  1; m<i>_readdata  out  DATA_WIDTH; m<i>_readdatavalid  out  1 (i=0,1).
REQ-009 SHALL have ports s_address/burstcount/read/write/writedata/byteenable  out  per parameters  shared local-memory bank command.
REQ-010 SHALL have ports s_waitrequest  in  1; s_readdata  in  DATA_WIDTH; s_readdatavalid  in  1.
REQ-011 SHALL have ports stat_m0_stall, stat_m1_stall  out  32  stall-cycle counters (see Configuration).

Function
REQ-012 Command forwarding SHALL be combinational: s_* mirror the granted requester's command; s_read/s_write SHALL be 0 when no requester is granted.
REQ-013 A command SHALL be accepted when m<i>_(read|write)=1 and m<i>_waitrequest=0; a write beat likewise.
REQ-014 m<i>_waitrequest SHALL be 1 unless i is granted, s_waitrequest=0, and (for reads) the read queue is not full.
REQ-015 The FSM SHALL have states ARB and WR_LOCK.
REQ-016 In ARB, a single requester SHALL be granted; with both requesting, the requester not granted last SHALL win (round-robin); last_grant SHALL update on every accepted command.
REQ-017 An accepted write first beat with burstcount=N>1 SHALL move to WR_LOCK, holding the grant until N beats are accepted, then return to ARB.
REQ-018 In WR_LOCK, reads from either requester and writes from the other SHALL be stalled.
REQ-019 burstcount=0 SHALL be treated as 1.
REQ-020 Each accepted read SHALL push {requester id, burstcount} into an in-order queue of RDQ_DEPTH entries.
REQ-021 Queue full SHALL stall new reads only; writes proceed.
REQ-022 Each s_readdatavalid beat SHALL route to the head entry's requester, registered: m<i>_readdatavalid and m<i>_readdata asserted exactly 1 cycle after the s_ beat; the other requester's readdatavalid SHALL be 0.
REQ-023 A head beat counter SHALL pop the entry on its final beat; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-024 Read push and return pop in the same cycle with queue full SHALL still stall the push (full is evaluated on registered occupancy).
REQ-025 s_readdatavalid with an empty queue SHALL be dropped; an assertion SHALL flag it in simulation.

Reset
REQ-026 On reset=1 at a clk edge: FSM->ARB, last_grant->1 (requester 0 wins first tie), queue empty, beat counters 0, m<i>_readdatavalid 0, stat counters 0.
REQ-027 Reset mid-burst or with reads outstanding SHALL discard all state; in-flight returns after reset SHALL be dropped per REQ-025.

Configuration
REQ-028 Macro LOCAL_MEM_ARB_STATS_EN: when defined, stat_m<i>_stall SHALL increment (saturating at 2^32-1) each cycle m<i>_(read|write)=1 and m<i>_waitrequest=1.
REQ-029 Without LOCAL_MEM_ARB_STATS_EN, stat_m<i>_stall SHALL be constant 0 and no counter logic SHALL be instantiated.

Verification
REQ-030 Both requesters issue single-beat reads every cycle, s_waitrequest=0 -> grants alternate 0,1,0,1 starting with 0; 100 reads each accepted in 200 cycles.
REQ-031 m0 write burstcount=4 while m1 requests a read -> m1 stalled 4 beats; m1 read accepted on the cycle after the 4th m0 beat.
REQ-032 m0 read burstcount=2 then m1 read burstcount=1; slave returns 3 beats D0,D1,D2 -> m0 gets D0,D1, m1 gets D2, each 1 cycle after the slave beat.
REQ-033 64 reads outstanding, no returns -> 65th read stalled; one final return beat -> read accepted the following cycle.
REQ-034 With LOCAL_MEM_ARB_STATS_EN, m1 held stalled 10 cycles by s_waitrequest=1 -> stat_m1_stall=10; without the macro -> 0.
REQ-035 Reset asserted during cycle 2 of a 4-beat write -> FSM in ARB after reset; m1 granted immediately if m1 alone requests.
